// File: rtl/veggie_read_sched.sv
// Operand-read scheduler for the VEGGIE vector register file: spreads one batch
// of port reads over the banks, merging identical registers and serialising conflicts.
module veggie_read_sched #(
  parameter int READ_PORTS = 4,
  parameter int NUM_BANKS  = 4,
  parameter int VIDX_W     = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             in_valid,
  output logic                             ready,
  input  logic [READ_PORTS-1:0]            req_ren,
  input  logic [READ_PORTS*VIDX_W-1:0]     req_vs,
  input  logic                             flush,
  output logic [NUM_BANKS-1:0]             bank_ren,
  output logic [NUM_BANKS*VIDX_W-1:0]      bank_vs,
  output logic [NUM_BANKS*READ_PORTS-1:0]  bank_tag,
  output logic                             conflict,
  output logic                             batch_done
);

  // Banks are selected by the low index bits; NUM_BANKS is a power of two.
  localparam logic [VIDX_W-1:0] BANK_MASK = VIDX_W'(NUM_BANKS - 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q;
  logic [READ_PORTS-1:0]   pending_q;
  logic [READ_PORTS-1:0]   pending_d;
  logic [READ_PORTS-1:0]   served;
  logic [VIDX_W-1:0]       vs_q [READ_PORTS];
  logic                    done_q;
  logic                    accept;
  logic                    found;
  logic [VIDX_W-1:0]       win_vs;

  assign ready      = !RST && (state_q == IDLE) && !flush;
  assign accept     = in_valid && ready;
  assign batch_done = done_q;
  assign conflict   = (state_q == ISSUE) && (pending_d != '0);

  // One round: per bank, the lowest pending port wins and drags along every
  // pending port reading the same register.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    bank_ren = '0;
    bank_vs  = '0;
    bank_tag = '0;
    served   = '0;
    found    = 1'b0;
    win_vs   = '0;
    if (state_q == ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        found  = 1'b0;
        win_vs = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
          if (!found && pending_q[p] && ((vs_q[p] & BANK_MASK) == VIDX_W'(b))) begin
            found  = 1'b1;
            win_vs = vs_q[p];
          end
        end
        if (found) begin
          bank_ren[b]                  = 1'b1;
          bank_vs[b*VIDX_W +: VIDX_W]  = win_vs;
          for (int p = 0; p < READ_PORTS; p++) begin
            if (pending_q[p] && (vs_q[p] == win_vs)) begin
              bank_tag[b*READ_PORTS + p] = 1'b1;
              served[p]                  = 1'b1;
            end
          end
        end
      end
    end
    pending_d = pending_q & ~served;
  end

  // NOTE: the register indices carry no reset; they are only observed through
  // pending bits, which are reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        vs_q[p] <= req_vs[p*VIDX_W +: VIDX_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            pending_q <= req_ren;
            if (req_ren != '0) begin
              state_q <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            pending_q <= '0;
            state_q   <= IDLE;
          end else begin
            pending_q <= pending_d;
            if (pending_d == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veggie_read_sched.sv
// Directed bench for veggie_read_sched: expected rounds are queued when a batch
// is driven and popped as the scheduler issues them.
module tb_veggie_read_sched;

  localparam int RP = 4;
  localparam int NB = 4;
  localparam int VW = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic              ready;
  logic [RP-1:0]     req_ren;
  logic [RP*VW-1:0]  req_vs;
  logic              flush;
  logic [NB-1:0]     bank_ren;
  logic [NB*VW-1:0]  bank_vs;
  logic [NB*RP-1:0]  bank_tag;
  logic              conflict;
  logic              batch_done;

  veggie_read_sched #(.READ_PORTS(RP), .NUM_BANKS(NB), .VIDX_W(VW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .ready      (ready),
    .req_ren    (req_ren),
    .req_vs     (req_vs),
    .flush      (flush),
    .bank_ren   (bank_ren),
    .bank_vs    (bank_vs),
    .bank_tag   (bank_tag),
    .conflict   (conflict),
    .batch_done (batch_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NB-1:0]    ren;
    logic [NB*VW-1:0] vs;
    logic [NB*RP-1:0] tag;
    logic             cfl;
  } round_t;

  round_t sb[$];
  int     n_assert = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [NB-1:0] ren, input logic [NB*VW-1:0] vs,
                      input logic [NB*RP-1:0] tag, input logic cfl);
    round_t r;
    r.ren = ren;
    r.vs  = vs;
    r.tag = tag;
    r.cfl = cfl;
    sb.push_back(r);
  endtask

  // Called at a negedge while idle; returns at the negedge of the first round.
  task automatic handshake(input logic [RP-1:0] ren, input logic [RP*VW-1:0] vs);
    chk("ready_before_batch", 32'(ready), 32'd1);
    in_valid = 1'b1;
    req_ren  = ren;
    req_vs   = vs;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    req_ren  = '0;
    @(negedge CLK);
  endtask

  task automatic check_round(input string name);
    round_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_scoreboard observed=0 entries expected=1 entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_bank_ren"},   32'(bank_ren),   32'(e.ren));
      chk({name, "_bank_vs"},    32'(bank_vs),    32'(e.vs));
      chk({name, "_bank_tag"},   32'(bank_tag),   32'(e.tag));
      chk({name, "_conflict"},   32'(conflict),   32'(e.cfl));
      chk({name, "_done_low"},   32'(batch_done), 32'd0);
      chk({name, "_ready_low"},  32'(ready),      32'd0);
    end
    @(negedge CLK);
  endtask

  task automatic check_done(input string name);
    chk({name, "_batch_done"}, 32'(batch_done), 32'd1);
    chk({name, "_ready"},      32'(ready),      32'd1);
    chk({name, "_bank_ren"},   32'(bank_ren),   32'd0);
    chk({name, "_conflict"},   32'(conflict),   32'd0);
    @(negedge CLK);
    chk({name, "_done_pulse"}, 32'(batch_done), 32'd0);
  endtask

  initial begin
    RST      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    req_ren  = '0;
    req_vs   = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_ready",      32'(ready),      32'd0);
    chk("rst_bank_ren",   32'(bank_ren),   32'd0);
    chk("rst_bank_tag",   32'(bank_tag),   32'd0);
    chk("rst_conflict",   32'(conflict),   32'd0);
    chk("rst_batch_done", 32'(batch_done), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // No conflict: vs0..vs3 = 0,1,2,3
    push(4'b1111, 32'h0302_0100, 16'h8421, 1'b0);
    handshake(4'b1111, 32'h0302_0100);
    check_round("noconf_r1");
    check_done("noconf");

    // Full conflict: vs0..vs3 = 0,4,8,12, all bank 0
    push(4'b0001, 32'h0000_0000, 16'h0001, 1'b1);
    push(4'b0001, 32'h0000_0004, 16'h0002, 1'b1);
    push(4'b0001, 32'h0000_0008, 16'h0004, 1'b1);
    push(4'b0001, 32'h0000_000C, 16'h0008, 1'b0);
    handshake(4'b1111, 32'h0C08_0400);
    check_round("full_r1");
    check_round("full_r2");
    check_round("full_r3");
    check_round("full_r4");
    check_done("full");

    // Merge: vs0..vs3 = 5,5,9,5, all bank 1
    push(4'b0010, 32'h0000_0500, 16'h00B0, 1'b1);
    push(4'b0010, 32'h0000_0900, 16'h0040, 1'b0);
    handshake(4'b1111, 32'h0509_0505);
    check_round("merge_r1");
    check_round("merge_r2");
    check_done("merge");

    // Mixed: vs0..vs3 = 1,5,2,1 -> bank1 merge + bank2 together, then vs5
    push(4'b0110, 32'h0002_0100, 16'h0490, 1'b1);
    push(4'b0010, 32'h0000_0500, 16'h0020, 1'b0);
    handshake(4'b1111, 32'h0102_0501);
    check_round("mixed_r1");
    check_round("mixed_r2");
    check_done("mixed");

    // Partial enable: only port 2 (vs=6, bank 2)
    push(4'b0100, 32'h0006_0000, 16'h0400, 1'b0);
    handshake(4'b0100, 32'h0706_0504);
    check_round("partial_r1");
    check_done("partial");

    // Empty batch
    handshake(4'b0000, 32'h0302_0100);
    check_done("empty");

    // Flush raised during round 2 of a full-conflict batch
    push(4'b0001, 32'h0000_0000, 16'h0001, 1'b1);
    push(4'b0001, 32'h0000_0004, 16'h0002, 1'b1);
    handshake(4'b1111, 32'h0C08_0400);
    check_round("flush_r1");
    flush = 1'b1;
    check_round("flush_r2");
    chk("flush_idle_ready_blocked", 32'(ready),      32'd0);
    chk("flush_bank_ren",           32'(bank_ren),   32'd0);
    chk("flush_no_done",            32'(batch_done), 32'd0);
    in_valid = 1'b1;
    req_ren  = 4'b1111;
    req_vs   = 32'h0302_0100;
    @(posedge CLK);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    req_ren  = '0;
    @(negedge CLK);
    chk("flush_blocked_bank_ren", 32'(bank_ren),   32'd0);
    chk("flush_blocked_done",     32'(batch_done), 32'd0);

    push(4'b1111, 32'h0302_0100, 16'h8421, 1'b0);
    handshake(4'b1111, 32'h0302_0100);
    check_round("after_flush_r1");
    check_done("after_flush");

    // Reset during round 2
    push(4'b0001, 32'h0000_0000, 16'h0001, 1'b1);
    push(4'b0001, 32'h0000_0004, 16'h0002, 1'b1);
    handshake(4'b1111, 32'h0C08_0400);
    check_round("rst_mid_r1");
    RST = 1'b1;
    check_round("rst_mid_r2");
    chk("rst_mid_bank_ren", 32'(bank_ren),   32'd0);
    chk("rst_mid_bank_vs",  32'(bank_vs),    32'd0);
    chk("rst_mid_bank_tag", 32'(bank_tag),   32'd0);
    chk("rst_mid_conflict", 32'(conflict),   32'd0);
    chk("rst_mid_done",     32'(batch_done), 32'd0);
    chk("rst_mid_ready",    32'(ready),      32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_ready_after", 32'(ready),      32'd1);
    chk("rst_mid_no_done",     32'(batch_done), 32'd0);

    push(4'b0010, 32'h0000_0500, 16'h00B0, 1'b1);
    push(4'b0010, 32'h0000_0900, 16'h0040, 1'b0);
    handshake(4'b1111, 32'h0509_0505);
    check_round("after_rst_r1");
    check_round("after_rst_r2");
    check_done("after_rst");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
